seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle integer ALU that executes the 4-bit ALUControl codes produced by the ALU decoder. It sits in the execute stage of the multi-cycle RISC-V core. Logic and arithmetic operations complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter to save area. Operands are accepted and results returned over valid/ready handshakes.

## Interface
- WIDTH, 32, datapath width in bits; must be a power of two ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  block can accept a request (high only in IDLE)
- ALUControl  input  4  operation code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount
- out_valid  output  1  result and zero flag are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- zero  output  1  registered; equals (result == 0), written together with result

## Operation
- ALUControl codes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed)
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1010–1111 execute as add
- Arithmetic:
  - add and sub wrap modulo 2^WIDTH.
  - slt and sltu return 1 or 0, zero-extended.
  - sra replicates a[WIDTH-1].
  - Shift amount uses only b[SHW-1:0]; upper bits of b are ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch operands. Non-shift op, or shift with amount 0: write result and zero, go to DONE. Nonzero shift: load acc=a and cnt=amount, go to SHIFT.
  - SHIFT: each cycle, acc shifts by one bit in the op's direction/fill and cnt decrements. The edge where cnt==1 writes result=shifted acc and its zero flag, then goes to DONE.
  - DONE: out_valid=1; result and zero held stable. On out_ready, go to IDLE.
- Requests are sampled only on the accept edge. Changes to a, b or ALUControl while the block is busy have no effect.
- No overlap: a new request is never accepted while in SHIFT or DONE.

## Timing
- Reset values (synchronous, dominant over all other inputs):
  - state = IDLE
  - in_ready = 1 the cycle after reset
  - out_valid = 0
  - result = 0
  - zero = 0
  - acc = 0
  - cnt = 0
- Latency, from the accept edge to out_valid high:
  - Non-shift ops: 1 cycle.
  - Shifts: 1 + amount cycles, maximum WIDTH cycles (amount = WIDTH-1).
- Throughput: at most one op every 2 cycles, since DONE→IDLE costs one cycle even with out_ready held high.
- out_valid, result and zero stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- Reset asserted in SHIFT or DONE: the operation is aborted, the result is discarded, and out_valid is 0 the next cycle.
- in_valid asserted during reset is ignored.

## Structure
- Package alu_pkg:
  - alu_op_t: 4-bit enum of the codes above, shared with the ALU decoder.
  - state_t: IDLE, SHIFT, DONE.
- Sub-module alu_comb: purely combinational single-cycle ops (add, sub, and, or, xor, slt, sltu) plus a one-bit shift step (left, logical right, arithmetic right).
- seq_alu contains the FSM, acc/cnt registers and output registers only.

## Test plan
- add a=0x7FFFFFFF, b=1 → out_valid 1 cycle after accept; result=0x80000000, zero=0.
- sub a=5, b=5 → result=0, zero=1. Then slt a=0xFFFFFFFF, b=1 → 1; sltu with the same operands → 0.
- sra a=0x80000000, b=0x0000003F (amount 31) → out_valid 32 cycles after accept; result=0xFFFFFFFF. in_ready=0 throughout.
- sll a=0x1, b=0 → 1-cycle latency, result=0x1. srl a=0xF0, b=4 → 5-cycle latency, result=0xF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable and in_valid ignored. Then pulse out_ready → IDLE next cycle, and the next op is accepted.
- Reset asserted on the 3rd SHIFT cycle of srl by 20 → next cycle: out_valid=0, result=0, in_ready=1. A following add 2+3 → result=5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl opcodes and FSM state shared by the ALU decoder and seq_alu.
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op == OP_SLL || op == OP_SRL || op == OP_SRA;
    endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle logic/arithmetic ops and a one-bit shift step.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] step
);
    always_comb begin
        y = op == OP_SUB  ? a - b :
            op == OP_AND  ? a & b :
            op == OP_OR   ? a | b :
            op == OP_XOR  ? a ^ b :
            op == OP_SLT  ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
            op == OP_SLTU ? {{(WIDTH-1){1'b0}}, a < b} :
                            a + b;
        // right shifts fill with the sign bit only for sra
        step = op == OP_SLL ? {a[WIDTH-2:0], 1'b0} : {op == OP_SRA && a[WIDTH-1], a[WIDTH-1:1]};
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes and a bit-serial shifter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] y, step;

    // during SHIFT the datapath steps the latched op on acc; otherwise it sees the live request
    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op   (state_q == SHIFT ? op_q : ALUControl),
        .a    (state_q == SHIFT ? acc_q : a),
        .b    (b),
        .y    (y),
        .step (step)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = ALUControl;
                if (is_shift(ALUControl) && b[SHW-1:0] != '0) begin
                    acc_d   = a;
                    cnt_d   = b[SHW-1:0];
                    state_d = SHIFT;
                end else begin
                    result_d = is_shift(ALUControl) ? a : y;
                    zero_d   = result_d == '0;
                    state_d  = DONE;
                end
            end
            SHIFT: begin
                acc_d = step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    result_d = step;
                    zero_d   = step == '0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table, corner sequences and random ops against a reference model.
module tb_seq_alu;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [3:0]  ALUControl = 0;
    logic [31:0] a = 0, b = 0, result;
    logic        in_ready, out_valid, zero;
    int          checks = 0, failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        zr;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int amt = int'(y[4:0]);
        case (op)
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: return (x < y) ? 32'd1 : 32'd0;
            4'd7: return x << amt;
            4'd8: return x >> amt;
            4'd9: return $unsigned($signed(x) >>> amt);
            default: return x + y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
        return (op >= 4'd7 && op <= 4'd9) ? 1 + int'(y[4:0]) : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // issue one op, scramble inputs while busy, then accept the result
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic zr, output int lat);
        logic busy_ready = 0;
        @(negedge clk);
        check("in_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1; ALUControl = op; a = x; b = y;
        @(posedge clk);
        #1 in_valid = 0; ALUControl = 4'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            busy_ready |= in_ready;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        if (lat > 1) check("in_ready_busy", {31'd0, busy_ready}, 32'd0);
        res = result; zr = zero;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    vec_t        tbl[$];
    logic [31:0] r;
    logic        z;
    int          l;

    initial begin
        tbl.push_back('{4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1});
        tbl.push_back('{4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1});
        tbl.push_back('{4'd5, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1});
        tbl.push_back('{4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1});
        tbl.push_back('{4'd9, 32'h80000000, 32'h3F, 32'hFFFFFFFF, 1'b0, 32});
        tbl.push_back('{4'd7, 32'h1, 32'h0, 32'h1, 1'b0, 1});
        tbl.push_back('{4'd8, 32'hF0, 32'h4, 32'hF, 1'b0, 5});
        tbl.push_back('{4'd2, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1});
        tbl.push_back('{4'd3, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1});
        tbl.push_back('{4'd4, 32'hAAAA, 32'hAAAA, 32'h0, 1'b1, 1});
        tbl.push_back('{4'd15, 32'd3, 32'd4, 32'd7, 1'b0, 1});
        tbl.push_back('{4'd7, 32'h1, 32'hFFFFFFE1, 32'h2, 1'b0, 2});
        tbl.push_back('{4'd7, 32'h80000001, 32'h1F, 32'h80000000, 1'b0, 32});
        tbl.push_back('{4'd8, 32'h80000000, 32'h1F, 32'h1, 1'b0, 32});
        tbl.push_back('{4'd9, 32'h40000000, 32'h1E, 32'h1, 1'b0, 31});

        in_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 0; in_valid = 0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, l);
            check($sformatf("vec%0d_result", i), r, tbl[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, tbl[i].zr});
            check($sformatf("vec%0d_lat", i), l, tbl[i].lat);
        end

        // backpressure: result held and requests ignored while out_ready low
        @(negedge clk);
        in_valid = 1; ALUControl = 4'd0; a = 32'd10; b = 32'd20;
        @(posedge clk);
        #1 a = 32'd1; b = 32'd1; ALUControl = 4'd1;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'd30);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1; in_valid = 0;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        run_op(4'd0, 32'd7, 32'd8, r, z, l);
        check("bp_next_result", r, 32'd15);

        // reset during the third SHIFT cycle of srl by 20
        @(negedge clk);
        in_valid = 1; ALUControl = 4'd8; a = 32'hFFFF0000; b = 32'd20;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (3) @(negedge clk);
        reset = 1; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 0; in_valid = 0;
        run_op(4'd0, 32'd2, 32'd3, r, z, l);
        check("abort_add_result", r, 32'd5);
        check("abort_add_lat", l, 1);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op = 4'($urandom_range(0, 15));
            logic [31:0] x = $urandom, y = $urandom;
            logic [31:0] e;
            if (i % 4 == 0) y = x;
            e = ref_alu(op, x, y);
            run_op(op, x, y, r, z, l);
            check($sformatf("rnd%0d_op%0d_result", i, op), r, e);
            check($sformatf("rnd%0d_zero", i), {31'd0, z}, {31'd0, e == 32'd0});
            check($sformatf("rnd%0d_lat", i), l, ref_lat(op, y));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
